align_add_floating_point32: RTL and testbench
=============================================

// Module: align_add_floating_point32
// PURPOSE
//   Alignment and mantissa add/subtract front end of the FP32 adder pipeline.
//   Accepts two IEEE-754 single operands plus an add/sub select, and aligns the smaller operand to the larger.
//   Adds or subtracts the 24-bit mantissas and emits {sign, larger_exponent, mantise_temp[24:0]} with valid.
//   Output feeds normalized_floating_point32 directly; its ports match that stage's inputs one-to-one.
// PARAMETERS
//   FLUSH_DENORMAL  1  1: exponent==0 operand treated as exact zero (hidden bit 0, fraction 0); 0: hidden bit 0, fraction kept
// PORTS
//   clk              in   1   clock, all state on rising edge
//   rstn             in   1   asynchronous active-low reset
//   valid_in         in   1   operand qualifier, one operation per asserted cycle
//   op_sub           in   1   0: a+b, 1: a-b
//   in_data_a        in   32  operand A, FP32
//   in_data_b        in   32  operand B, FP32
//   valid_out        out  1   result qualifier
//   sign             out  1   result sign
//   larger_exponent  out  8   exponent of larger-magnitude operand
//   mantise_temp     out  25  unnormalized result; bit24 = carry, bit23 = hidden-bit position
// BEHAVIOUR
//   Reset: valid_out=0, sign=0, larger_exponent=0, mantise_temp=0; all internal stage registers 0. Reset is asynchronous, mid-stream included.
//   Latency: fixed 3 cycles valid_in->valid_out. Throughput 1/cycle. No backpressure, no stall.
//   Valid shift chain v1<=valid_in, v2<=v1, valid_out<=v2 every cycle.
//   Each stage's data registers load only when its incoming valid=1, else hold the previous value.
//   Stage 1 (unpack/compare):
//     - eff_sign_b = in_data_b[31]^op_sub; mant_x = {hidden, frac[22:0]}, hidden = (exp!=0).
//     - Larger = operand with greater {exp,frac}. On a tie pick A.
//     - Register sign_L, sign_S, exp_L, delta = exp_L-exp_S (8b, never negative), mant_L, mant_S.
//   Stage 2 (align):
//     - mant_S_al = (delta>=24) ? 0 : mant_S>>delta. Truncation; no guard/round/sticky bits.
//     - eff_sub = sign_L^sign_S. Pass sign_L, exp_L, mant_L.
//   Stage 3 (add/sub):
//     - mantise_temp = eff_sub ? {1'b0,mant_L}-{1'b0,mant_S_al} : {1'b0,mant_L}+{1'b0,mant_S_al}.
//     - Result is 25b and never negative because |L|>=|S|. sign = sign_L.
//     - Exact cancellation (mantise_temp==0 with eff_sub=1): sign forced to 0 (+0).
//     - larger_exponent = exp_L.
//   Special values:
//     - Either exp==0xFF: larger_exponent=0xFF. Mantissa is don't-care; downstream forces 0.
//     - NaN is not distinguished from infinity.
//     - Both operands zero: exp 0, mantise_temp 0, sign = sign_A & eff_sign_b.
//   Simultaneous events: valid_in asserted every cycle yields independent results in order.
//     No state crosses operations except held registers.
// TESTING
//   1.0+1.0 (0x3F800000,0x3F800000,op_sub=0) -> 3 cycles later valid_out=1, sign=0, exp=0x7F, mant=0x1000000
//   1.5-1.0 (0x3FC00000,0x3F800000,op_sub=1) -> sign=0, exp=0x7F, mant=0x0400000
//   1.0-2.0 (0x3F800000,0x40000000,op_sub=1) -> sign=1, exp=0x80, mant=0x0400000
//   1.0+2^-24 (0x3F800000,0x33800000) -> delta=24 shifts out: sign=0, exp=0x7F, mant=0x0800000; x-x (0x40490FDB both, op_sub=1) -> sign=0, mant=0
//   +inf+1.0 (0x7F800000,0x3F800000) -> exp=0xFF, sign=0
//   Back-to-back: 8 random ops on consecutive cycles -> 8 consecutive matching results vs. model.
//     Deassert rstn mid-burst -> valid_out and all outputs 0 immediately; no stale valid after release.

Source files
------------

// File: rtl/align_add_floating_point32.sv
// FP32 adder front end: unpack/compare, align the smaller mantissa, then add/subtract.
// Three registered stages, one operation per cycle, no stall.
module align_add_floating_point32 #(
  parameter bit FLUSH_DENORMAL = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic        op_sub,
  input  logic [31:0] in_data_a,
  input  logic [31:0] in_data_b,
  output logic        valid_out,
  output logic        sign,
  output logic [7:0]  larger_exponent,
  output logic [24:0] mantise_temp
);

  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic [23:0] mant_a, mant_b;
  logic        eff_sign_b, a_larger;

  // Exponent-zero operands lose their fraction when flushing, so they also compare as zero
  always_comb begin
    exp_a      = in_data_a[30:23];
    exp_b      = in_data_b[30:23];
    frac_a     = (FLUSH_DENORMAL && (exp_a == 8'd0)) ? 23'd0 : in_data_a[22:0];
    frac_b     = (FLUSH_DENORMAL && (exp_b == 8'd0)) ? 23'd0 : in_data_b[22:0];
    mant_a     = {(exp_a != 8'd0), frac_a};
    mant_b     = {(exp_b != 8'd0), frac_b};
    eff_sign_b = in_data_b[31] ^ op_sub;
    a_larger   = ({exp_a, frac_a} >= {exp_b, frac_b});
  end

  logic        v1, v2;
  logic        s1_sign_l, s1_sign_s;
  logic [7:0]  s1_exp_l, s1_delta;
  logic [23:0] s1_mant_l, s1_mant_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1        <= 1'b0;
      s1_sign_l <= 1'b0;
      s1_sign_s <= 1'b0;
      s1_exp_l  <= 8'd0;
      s1_delta  <= 8'd0;
      s1_mant_l <= 24'd0;
      s1_mant_s <= 24'd0;
    end else begin
      v1 <= valid_in;
      if (valid_in) begin
        if (a_larger) begin
          s1_sign_l <= in_data_a[31];
          s1_sign_s <= eff_sign_b;
          s1_exp_l  <= exp_a;
          s1_delta  <= exp_a - exp_b;
          s1_mant_l <= mant_a;
          s1_mant_s <= mant_b;
        end else begin
          s1_sign_l <= eff_sign_b;
          s1_sign_s <= in_data_a[31];
          s1_exp_l  <= exp_b;
          s1_delta  <= exp_b - exp_a;
          s1_mant_l <= mant_b;
          s1_mant_s <= mant_a;
        end
      end
    end
  end

  logic        s2_sign_l, s2_eff_sub;
  logic [7:0]  s2_exp_l;
  logic [23:0] s2_mant_l, s2_mant_s_al;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2           <= 1'b0;
      s2_sign_l    <= 1'b0;
      s2_eff_sub   <= 1'b0;
      s2_exp_l     <= 8'd0;
      s2_mant_l    <= 24'd0;
      s2_mant_s_al <= 24'd0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2_sign_l    <= s1_sign_l;
        s2_eff_sub   <= s1_sign_l ^ s1_sign_s;
        s2_exp_l     <= s1_exp_l;
        s2_mant_l    <= s1_mant_l;
        s2_mant_s_al <= (s1_delta >= 8'd24) ? 24'd0 : (s1_mant_s >> s1_delta);
      end
    end
  end

  logic [24:0] sum;

  always_comb begin
    sum = s2_eff_sub ? ({1'b0, s2_mant_l} - {1'b0, s2_mant_s_al})
                     : ({1'b0, s2_mant_l} + {1'b0, s2_mant_s_al});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out       <= 1'b0;
      sign            <= 1'b0;
      larger_exponent <= 8'd0;
      mantise_temp    <= 25'd0;
    end else begin
      valid_out <= v2;
      if (v2) begin
        // exact cancellation yields +0
        sign            <= s2_sign_l & ~(s2_eff_sub && (sum == 25'd0));
        larger_exponent <= s2_exp_l;
        mantise_temp    <= sum;
      end
    end
  end

endmodule

// File: tb/tb_align_add_floating_point32.sv
// Directed bench for align_add_floating_point32: single ops, boundaries, a back-to-back burst and mid-burst reset.
module tb_align_add_floating_point32;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_in;
  logic        op_sub;
  logic [31:0] in_data_a, in_data_b;
  logic        valid_out, sign;
  logic [7:0]  larger_exponent;
  logic [24:0] mantise_temp;

  int n_cmp = 0;
  int n_err = 0;

  align_add_floating_point32 dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .op_sub(op_sub),
    .in_data_a(in_data_a), .in_data_b(in_data_b),
    .valid_out(valid_out), .sign(sign),
    .larger_exponent(larger_exponent), .mantise_temp(mantise_temp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: returns {sign, exp[7:0], mant[24:0]} for flushed-denormal behaviour
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [7:0]  ea, eb, el, d;
    logic [23:0] ma, mb, ml, ms;
    logic        sa, sb, sl, ss;
    logic [24:0] r;
    ea = a[30:23]; eb = b[30:23];
    ma = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
    sa = a[31]; sb = b[31] ^ sub;
    if ({ea, ma} >= {eb, mb}) begin el = ea; d = ea - eb; ml = ma; ms = mb; sl = sa; ss = sb; end
    else begin el = eb; d = eb - ea; ml = mb; ms = ma; sl = sb; ss = sa; end
    if (d > 23) ms = 0; else ms = ms >> d;
    if (sl != ss) r = {1'b0, ml} - {1'b0, ms}; else r = {1'b0, ml} + {1'b0, ms};
    if (sl != ss && r == 0) sl = 1'b0;
    return {sl, el, r};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic es, input logic [7:0] ee, input logic [24:0] em, input bit chk_mant);
    @(negedge clk);
    in_data_a = a; in_data_b = b; op_sub = sub; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    chk({tag, "_sign"}, {31'd0, sign}, {31'd0, es});
    chk({tag, "_exp"}, {24'd0, larger_exponent}, {24'd0, ee});
    if (chk_mant) chk({tag, "_mant"}, {7'd0, mantise_temp}, {7'd0, em});
    @(negedge clk);
    chk({tag, "_single"}, {31'd0, valid_out}, 32'd0);
  endtask

  logic [31:0] va[8], vb[8];
  logic        vs[8];
  logic [33:0] expq[$];
  logic [33:0] e;
  int          got;

  initial begin
    rstn = 1'b0; valid_in = 1'b0; op_sub = 1'b0; in_data_a = '0; in_data_b = '0;
    #1;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_data", {sign, larger_exponent, mantise_temp}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_op("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 8'h7F, 25'h1000000, 1);
    run_op("1p5_minus_1",    32'h3FC00000, 32'h3F800000, 1'b1, 1'b0, 8'h7F, 25'h0400000, 1);
    run_op("1_minus_2",      32'h3F800000, 32'h40000000, 1'b1, 1'b1, 8'h80, 25'h0400000, 1);
    run_op("delta24",        32'h3F800000, 32'h33800000, 1'b0, 1'b0, 8'h7F, 25'h0800000, 1);
    run_op("delta23",        32'h3F800000, 32'h34000000, 1'b0, 1'b0, 8'h7F, 25'h0800001, 1);
    run_op("pi_minus_pi",    32'h40490FDB, 32'h40490FDB, 1'b1, 1'b0, 8'h80, 25'h0000000, 1);
    run_op("inf_plus_1",     32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 25'h0, 0);
    run_op("neg0_plus_neg0", 32'h80000000, 32'h80000000, 1'b0, 1'b1, 8'h00, 25'h0000000, 1);
    run_op("pos0_minus_pos0",32'h00000000, 32'h00000000, 1'b1, 1'b0, 8'h00, 25'h0000000, 1);
    run_op("denorm_flush",   32'h00000001, 32'h00000001, 1'b0, 1'b0, 8'h00, 25'h0000000, 1);
    run_op("neg1_plus_half", 32'hBF800000, 32'h3F000000, 1'b0, 1'b1, 8'h7F, 25'h0400000, 1);

    // back-to-back burst of 8 operations
    for (int i = 0; i < 8; i++) begin
      va[i] = {$urandom_range(0, 1), 8'($urandom_range(8'h70, 8'h8F)), 23'($urandom)};
      vb[i] = {$urandom_range(0, 1), 8'($urandom_range(8'h70, 8'h8F)), 23'($urandom)};
      vs[i] = 1'($urandom_range(0, 1));
    end
    vb[3] = va[3]; vs[3] = 1'b1; vb[3][31] = va[3][31];
    got = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("burst_valid", {31'd0, valid_out}, {31'd0, (c >= 3 && c <= 10)});
      if (valid_out && expq.size() > 0) begin
        e = expq.pop_front();
        chk("burst_result", {7'd0, sign, mantise_temp}, {7'd0, e[33], e[24:0]});
        chk("burst_exp", {24'd0, larger_exponent}, {24'd0, e[32:25]});
        got++;
      end
      if (c < 8) begin
        in_data_a = va[c]; in_data_b = vb[c]; op_sub = vs[c]; valid_in = 1'b1;
        expq.push_back(model(va[c], vb[c], vs[c]));
      end else valid_in = 1'b0;
    end
    chk("burst_count", got, 32'd8);

    // asynchronous reset in the middle of a burst
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_data_a = 32'h3F800000; in_data_b = 32'h3F800000; op_sub = 1'b0; valid_in = 1'b1;
    end
    @(posedge clk);
    #2;
    chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_rst_data", {sign, larger_exponent, mantise_temp}, 32'd0);
    valid_in = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_stale", {31'd0, valid_out}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
